// File: rtl/video_source_arbiter.sv
// -----------------------------------------------------------------------------
// video_source_arbiter
//   Selects one of three pixel sources (or black) for a single video sink.
//   Source changes requested on SrcSelect take effect only at a frame
//   boundary, so the sink never sees a frame stitched from two sources.
//
//   Optional feature (macro VIDEO_SRC_SWITCH_BLANK_EN): every source change
//   inserts one full black frame before the new source is granted.
//
// Parameters
//   H_ACTIVE       pixels per line
//   V_ACTIVE       lines per frame
// Ports
//   Clock          system clock, rising edge
//   Reset          synchronous, active-high reset
//   VideoReady     sink accepts the pixel on Video this cycle
//   SrcSelect      requested source (0..2 = Src0..Src2, 3 = black)
//   SrcNVideo      per-source 24-bit {R,G,B} pixel
//   SrcNReady      per-source pixel-advance strobe (combinational)
//   Video          pixel presented to the sink (combinational)
//   ActiveSrc      source currently granted
//   FrameStart     first pixel of a frame accepted this cycle (combinational)
//   SwitchPending  a source change is requested but not yet applied
// -----------------------------------------------------------------------------
module video_source_arbiter #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned V_ACTIVE = 600
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        VideoReady,
    input  logic [1:0]  SrcSelect,
    input  logic [23:0] Src0Video,
    input  logic [23:0] Src1Video,
    input  logic [23:0] Src2Video,
    output logic        Src0Ready,
    output logic        Src1Ready,
    output logic        Src2Ready,
    output logic [23:0] Video,
    output logic [1:0]  ActiveSrc,
    output logic        FrameStart,
    output logic        SwitchPending
);

    localparam int unsigned COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int unsigned PIX_W = 24;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [1:0]       active_q, active_d;
    logic             last_col, last_row, eof;
    logic             run;

    assign last_col = (col_q == COL_W'(H_ACTIVE - 1));
    assign last_row = (row_q == ROW_W'(V_ACTIVE - 1));
    assign eof      = VideoReady && last_col && last_row;

`ifdef VIDEO_SRC_SWITCH_BLANK_EN
    typedef enum logic {
        RUN   = 1'b0,
        BLANK = 1'b1
    } state_t;

    state_t state_q, state_d;

    assign run = (state_q == RUN);

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and grant update: a change first enters a black frame,
    // and the grant is reloaded from SrcSelect at the end of that frame.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        if (eof) begin
            case (state_q)
                RUN: begin
                    if (SrcSelect != active_q) begin
                        state_d = BLANK;
                    end
                end
                BLANK: begin
                    active_d = SrcSelect;
                    state_d  = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end
`else
    assign run = 1'b1;

    // Grant update: only at end-of-frame, and only if still requested then
    always_comb begin
        active_d = active_q;
        if (eof && (SrcSelect != active_q)) begin
            active_d = SrcSelect;
        end
    end
`endif

    // Raster position, advancing once per accepted pixel
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (VideoReady) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Counter and grant registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            col_q    <= '0;
            row_q    <= '0;
            active_q <= 2'd0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            active_q <= active_d;
        end
    end

    // Zero-latency pixel mux; black for source 3 or during a blank frame
    always_comb begin
        Video = '0;
        if (run) begin
            case (active_q)
                2'd0:    Video = Src0Video;
                2'd1:    Video = Src1Video;
                2'd2:    Video = Src2Video;
                default: Video = PIX_W'(0);
            endcase
        end
    end

    assign Src0Ready     = VideoReady && !Reset && run && (active_q == 2'd0);
    assign Src1Ready     = VideoReady && !Reset && run && (active_q == 2'd1);
    assign Src2Ready     = VideoReady && !Reset && run && (active_q == 2'd2);
    assign FrameStart    = VideoReady && !Reset && (col_q == '0) && (row_q == '0);
    assign SwitchPending = !run || (SrcSelect != active_q);
    assign ActiveSrc     = active_q;

endmodule

// File: doc/video_source_arbiter.md
VIDEO_SOURCE_ARBITER -- requirements
Module: video_source_arbiter

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 800, pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 600, lines per frame.
REQ-003 Clock  input  1  system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 VideoReady  input  1  sink accepts the pixel on Video this cycle.
REQ-006 SrcSelect  input  2  requested source; 0..2 select Src0..Src2, 3 selects black.
REQ-007 Src0Video, Src1Video, Src2Video  input  24  per-source RGB pixel {R,G,B}.
REQ-008 Src0Ready, Src1Ready, Src2Ready  output  1  per-source pixel-advance strobe.
REQ-009 Video  output  24  pixel presented to the sink.
REQ-010 ActiveSrc  output  2  source currently granted.
REQ-011 FrameStart  output  1  high when the first pixel of a frame is accepted.
REQ-012 SwitchPending  output  1  a source change is requested but not yet applied.

Function
REQ-013 Column counter SHALL count 0..H_ACTIVE-1 and row counter 0..V_ACTIVE-1; they SHALL advance only on cycles with VideoReady=1.
REQ-014 Column SHALL wrap to 0 after H_ACTIVE-1 and increment row; row SHALL wrap to 0 after V_ACTIVE-1.
REQ-015 End-of-frame (EOF) SHALL be the cycle where VideoReady=1, column=H_ACTIVE-1 and row=V_ACTIVE-1.
REQ-016 Video SHALL be a zero-latency combinational mux of SrcNVideo by ActiveSrc; ActiveSrc=3 or state BLANK SHALL give 24'h000000.
REQ-017 SrcNReady SHALL equal VideoReady AND (ActiveSrc==N) AND (state==RUN); at most one SrcNReady high per cycle.
REQ-018 FrameStart SHALL equal VideoReady AND column==0 AND row==0 AND not Reset.
REQ-019 State machine SHALL have states RUN and BLANK (BLANK reachable only per REQ-028).
REQ-020 SwitchPending SHALL equal (SrcSelect != ActiveSrc) in RUN and 1 in BLANK.
REQ-021 In RUN, at EOF with SrcSelect != ActiveSrc, ActiveSrc SHALL load SrcSelect sampled on that cycle, effective from the next accepted pixel.
REQ-022 ActiveSrc SHALL never change except at EOF; a request withdrawn before EOF SHALL cause no switch.
REQ-023 SrcSelect changes on non-EOF cycles SHALL have no effect on Video, ready strobes or counters.
REQ-024 VideoReady=0 SHALL hold all counters, state and ActiveSrc; no SrcNReady SHALL assert.

Reset
REQ-025 On Reset=1: counters 0, ActiveSrc 0, state RUN, applied at the next rising edge.
REQ-026 While Reset=1, all SrcNReady and FrameStart SHALL be 0; Video SHALL follow REQ-016.
REQ-027 Reset mid-frame SHALL abandon the frame; the first accepted pixel after Reset SHALL assert FrameStart.

Configuration
REQ-028 With VIDEO_SRC_SWITCH_BLANK_EN defined, an EOF switch per REQ-021 SHALL instead enter BLANK for one full frame (H_ACTIVE*V_ACTIVE accepted pixels) outputting black with no SrcNReady; at the EOF of the blank frame ActiveSrc SHALL load SrcSelect sampled then and state SHALL return to RUN.
REQ-029 Without VIDEO_SRC_SWITCH_BLANK_EN, BLANK SHALL not be implemented and switching SHALL follow REQ-021 directly.

Verification (H_ACTIVE=4, V_ACTIVE=2)
REQ-030 Reset, VideoReady=1 constant, SrcSelect=0, Src0Video=24'h1ABC9C -> Video=24'h1ABC9C, Src0Ready=1 every cycle, FrameStart every 8th cycle starting at cycle 0 after reset.
REQ-031 SrcSelect 0->1 at pixel 3 -> SwitchPending=1 pixels 3..7, ActiveSrc=1 and Src1Ready from pixel 8 (next FrameStart).
REQ-032 SrcSelect 0->2 at pixel 2, back to 0 at pixel 5 -> no switch, SwitchPending=1 only pixels 2..4.
REQ-033 VideoReady toggling 1,0 with SrcSelect=3 -> Video=0, no SrcNReady, counters advance only on VideoReady=1, FrameStart every 16 cycles.
REQ-034 Reset asserted at pixel 5 -> next accepted pixel has FrameStart=1, ActiveSrc=0.
REQ-035 With VIDEO_SRC_SWITCH_BLANK_EN, SrcSelect 0->1 mid-frame -> after EOF 8 black pixels with no readies, then ActiveSrc=1 and Src1Ready.
